load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the core's execute stage and the data-memory port (single-port RAM, req/gnt/rvalid protocol).
- Accepts one load or store per transaction and drives a word-aligned memory request with byte enables.
- Replicates store data across byte lanes, and aligns and sign/zero-extends load data.
- Stalls the pipeline while a transaction is outstanding, and flags misaligned or illegal accesses without touching memory.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; fixed at 32, and any other value is unsupported.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- ex_req_i  in  1  access request from execute stage
- ex_we_i  in  1  1 = store, 0 = load
- ex_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- ex_unsigned_i  in  1  load zero-extend (LBU/LHU)
- ex_addr_i  in  32  byte address
- ex_wdata_i  in  32  store data, LSB-justified
- lsu_busy_o  out  1  stall to pipeline
- lsu_done_o  out  1  one-cycle completion pulse
- lsu_rdata_o  out  32  extended load result, valid with lsu_done_o
- lsu_err_o  out  1  one-cycle pulse: misaligned or illegal size
- data_req_o  out  1  memory request
- data_gnt_i  in  1  memory grant
- data_addr_o  out  32  word address, bits [1:0] = 0
- data_we_o  out  1  memory write enable
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  lane-replicated store data
- data_rvalid_i  in  1  response valid (loads and stores)
- data_rdata_i  in  32  raw read word

Behaviour:
- FSM states are IDLE, REQ and WAIT_RV. Reset (rst=1 at an edge) forces IDLE and clears all registered outputs to 0.
- IDLE:
  - Accept happens when ex_req_i=1 and the access is legal. The unit latches addr, we, size, unsigned, be and wdata, then goes to REQ.
  - If the access is illegal, it stays in IDLE, pulses lsu_err_o the next cycle, and issues no memory request.
- Illegal access means any of: size=11; half with addr[0]=1; word with addr[1:0]!=0.
- REQ:
  - data_req_o=1, and address, write enable, byte enables and write data are held stable.
  - When data_gnt_i=1: data_req_o drops at the next edge and the FSM goes to WAIT_RV.
  - While data_gnt_i=0: the request stays in REQ indefinitely.
- WAIT_RV:
  - The unit waits for data_rvalid_i. When it arrives, lsu_done_o=1 for one cycle starting the next cycle, lsu_rdata_o is registered from the aligned data, and the FSM returns to IDLE.
  - data_rvalid_i is ignored in every other state. Memory guarantees rvalid at least 1 cycle after gnt.
- lsu_busy_o is combinational: (state!=IDLE) | (ex_req_i & legal & state==IDLE). The stall is therefore raised in the accept cycle, and it drops in the cycle lsu_done_o is high.
- Minimum latency with gnt in the first REQ cycle and rvalid one cycle later: accept at T0, req at T1, rvalid at T2, done at T3.
- Store lanes:
  - byte: BE = 0001 << addr[1:0], wdata = {4{b}}.
  - half: BE = 0011 << addr[1:0], wdata = {2{h}}.
  - word: BE = 1111.
- Load align: shift = data_rdata_i >> (8*addr[1:0]). Byte and half results are sign- or zero-extended per ex_unsigned_i. Word results pass through unchanged.
- lsu_rdata_o holds its last value until the next load completes. A store completion leaves lsu_rdata_o unchanged.
- ex_req_i while busy is not accepted. The execute stage must hold the request until lsu_busy_o falls.
- Reset mid-transaction: the unit returns to IDLE at the edge and data_req_o=0 next cycle. Any late rvalid is ignored and no done pulse is produced.

Decomposition:
- Package riscv_lsu_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - FSM state encodings LSU_IDLE, LSU_REQ, LSU_WAIT_RV;
  - the legality-check function.
- One combinational sub-module, lsu_align, generates byte enables and store-lane replication, and performs load extraction and extension. The FSM stays in load_store_unit.

Test Plan:
- LB at addr 0x103, mem word 0x80FF_1234, gnt immediate, rvalid +1 -> lsu_done_o at T3, lsu_rdata_o=0xFFFF_FF80; LBU same access -> 0x0000_0080.
- SH data 0x0000_BEEF at addr 0x202 -> data_addr_o=0x200, data_be_o=1100, data_wdata_o=0xBEEF_BEEF, data_we_o=1; memory word afterwards 0xBEEF_xxxx with lower half unchanged.
- SW 0xDEAD_BEEF at 0x300 with data_gnt_i held low 5 cycles -> data_req_o high for 6 cycles with address, BE and data stable, lsu_busy_o high throughout, done exactly once.
- LW at 0x101 and LH at 0x103 -> lsu_err_o pulse each, data_req_o never asserted, lsu_busy_o low; size=11 -> lsu_err_o.
- Back-to-back: SW 0x1234_5678 to 0x40 then LW 0x40 with ex_req_i held -> second request accepted in the lsu_done_o cycle, load returns 0x1234_5678.
- rst asserted in WAIT_RV, rvalid arrives the next cycle -> state IDLE, no lsu_done_o, lsu_rdata_o=0, data_req_o=0.

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// Shared encodings and the access-legality rule for the load/store unit.
package riscv_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE    = 2'b00,
    LSU_REQ     = 2'b01,
    LSU_WAIT_RV = 2'b10
  } lsu_state_e;

  // Natural alignment is required; size 2'b11 has no meaning.
  function automatic logic lsu_legal(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~addr_lo[0];
      SZ_WORD: ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables and lane replication, and
// load extraction with sign/zero extension.
module lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_ext
);

  logic [31:0] ld_shift_s;

  // Store side: enables follow the byte offset, data is replicated on every lane.
  always_comb begin
    st_be    = 4'b0000;
    st_lanes = st_wdata;
    case (st_size)
      SZ_BYTE: begin
        st_be    = 4'b0001 << st_addr_lo;
        st_lanes = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_be    = 4'b0011 << st_addr_lo;
        st_lanes = {2{st_wdata[15:0]}};
      end
      SZ_WORD: begin
        st_be    = 4'b1111;
        st_lanes = st_wdata;
      end
      default: begin
        st_be    = 4'b0000;
        st_lanes = st_wdata;
      end
    endcase
  end

  // Load side: bring the addressed byte/half down to bit 0, then extend.
  always_comb begin
    ld_shift_s = ld_rdata >> {ld_addr_lo, 3'b000};
    ld_ext     = ld_rdata;
    case (ld_size)
      SZ_BYTE: ld_ext = ld_unsigned ? {24'h000000, ld_shift_s[7:0]}
                                    : {{24{ld_shift_s[7]}}, ld_shift_s[7:0]};
      SZ_HALF: ld_ext = ld_unsigned ? {16'h0000, ld_shift_s[15:0]}
                                    : {{16{ld_shift_s[15]}}, ld_shift_s[15:0]};
      SZ_WORD: ld_ext = ld_rdata;
      default: ld_ext = ld_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one transaction at a time from execute to a req/gnt/rvalid
// data-memory port, with misaligned/illegal accesses rejected locally.
module load_store_unit
  import riscv_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_req_i,
  input  logic              ex_we_i,
  input  logic [1:0]        ex_size_i,
  input  logic              ex_unsigned_i,
  input  logic [ADDR_W-1:0] ex_addr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  output logic              lsu_busy_o,
  output logic              lsu_done_o,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              lsu_err_o,
  output logic              data_req_o,
  input  logic              data_gnt_i,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [DATA_W-1:0] data_wdata_o,
  input  logic              data_rvalid_i,
  input  logic [DATA_W-1:0] data_rdata_i
);

  lsu_state_e        state_r;
  logic              req_r;
  logic [ADDR_W-1:0] addr_r;
  logic              we_r;
  logic [3:0]        be_r;
  logic [DATA_W-1:0] wdata_r;
  logic [1:0]        size_r;
  logic              uns_r;
  logic [1:0]        addr_lo_r;
  logic              done_r;
  logic              err_r;
  logic [DATA_W-1:0] rdata_r;

  logic              legal_s;
  logic [3:0]        be_s;
  logic [DATA_W-1:0] lanes_s;
  logic [DATA_W-1:0] ext_s;

  assign legal_s = lsu_legal(ex_size_i, ex_addr_i[1:0]);

  // Store formatting uses the live execute inputs (captured at accept);
  // load extension uses the attributes latched with the request.
  lsu_align u_align (
    .st_size     (ex_size_i),
    .st_addr_lo  (ex_addr_i[1:0]),
    .st_wdata    (ex_wdata_i),
    .ld_size     (size_r),
    .ld_unsigned (uns_r),
    .ld_addr_lo  (addr_lo_r),
    .ld_rdata    (data_rdata_i),
    .st_be       (be_s),
    .st_lanes    (lanes_s),
    .ld_ext      (ext_s)
  );

  // Transaction FSM with all memory-side and result outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= LSU_IDLE;
      req_r     <= 1'b0;
      addr_r    <= {ADDR_W{1'b0}};
      we_r      <= 1'b0;
      be_r      <= 4'b0000;
      wdata_r   <= {DATA_W{1'b0}};
      size_r    <= 2'b00;
      uns_r     <= 1'b0;
      addr_lo_r <= 2'b00;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      rdata_r   <= {DATA_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        LSU_IDLE: begin
          if (ex_req_i && legal_s) begin
            req_r     <= 1'b1;
            addr_r    <= {ex_addr_i[ADDR_W-1:2], 2'b00};
            we_r      <= ex_we_i;
            be_r      <= be_s;
            wdata_r   <= lanes_s;
            size_r    <= ex_size_i;
            uns_r     <= ex_unsigned_i;
            addr_lo_r <= ex_addr_i[1:0];
            state_r   <= LSU_REQ;
          end else if (ex_req_i) begin
            err_r <= 1'b1;
          end
        end
        LSU_REQ: begin
          if (data_gnt_i) begin
            req_r   <= 1'b0;
            state_r <= LSU_WAIT_RV;
          end
        end
        LSU_WAIT_RV: begin
          if (data_rvalid_i) begin
            done_r  <= 1'b1;
            if (!we_r) begin
              rdata_r <= ext_s;
            end
            state_r <= LSU_IDLE;
          end
        end
        default: begin
          req_r   <= 1'b0;
          state_r <= LSU_IDLE;
        end
      endcase
    end
  end

  assign lsu_busy_o   = (state_r != LSU_IDLE) | (ex_req_i & legal_s & (state_r == LSU_IDLE));
  assign lsu_done_o   = done_r;
  assign lsu_rdata_o  = rdata_r;
  assign lsu_err_o    = err_r;
  assign data_req_o   = req_r;
  assign data_addr_o  = addr_r;
  assign data_we_o    = we_r;
  assign data_be_o    = be_r;
  assign data_wdata_o = wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small req/gnt/rvalid memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_req = 1'b0;
  logic        ex_we = 1'b0;
  logic [1:0]  ex_size = 2'b00;
  logic        ex_uns = 1'b0;
  logic [31:0] ex_addr = 32'h0;
  logic [31:0] ex_wdata = 32'h0;
  logic        lsu_busy, lsu_done, lsu_err;
  logic [31:0] lsu_rdata;
  logic        data_req, data_gnt, data_we;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_be;
  logic        data_rvalid = 1'b0;
  logic [31:0] data_rdata = 32'h0;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:255];
  int          gnt_delay = 0;
  int          rv_delay = 1;
  int          stall_cnt = 0;
  int          rv_cnt = 0;
  logic [31:0] rv_data = 32'h0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .ex_req_i(ex_req), .ex_we_i(ex_we), .ex_size_i(ex_size), .ex_unsigned_i(ex_uns),
    .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata),
    .lsu_busy_o(lsu_busy), .lsu_done_o(lsu_done), .lsu_rdata_o(lsu_rdata), .lsu_err_o(lsu_err),
    .data_req_o(data_req), .data_gnt_i(data_gnt), .data_addr_o(data_addr), .data_we_o(data_we),
    .data_be_o(data_be), .data_wdata_o(data_wdata), .data_rvalid_i(data_rvalid),
    .data_rdata_i(data_rdata)
  );

  // Memory model: grant after gnt_delay waiting cycles, rvalid rv_delay cycles after grant.
  assign data_gnt = data_req && (stall_cnt >= gnt_delay);

  always @(posedge clk) begin
    data_rvalid <= 1'b0;
    if (rv_cnt > 0) begin
      rv_cnt <= rv_cnt - 1;
      if (rv_cnt == 1) begin
        data_rvalid <= 1'b1;
        data_rdata  <= rv_data;
      end
    end
    if (data_req && !data_gnt) begin
      stall_cnt <= stall_cnt + 1;
    end else if (data_gnt) begin
      stall_cnt <= 0;
      if (data_we) begin
        for (int b = 0; b < 4; b++) begin
          if (data_be[b]) mem[data_addr[9:2]][8*b +: 8] <= data_wdata[8*b +: 8];
        end
      end
      if (rv_delay <= 1) begin
        data_rvalid <= 1'b1;
        data_rdata  <= mem[data_addr[9:2]];
      end else begin
        rv_cnt  <= rv_delay - 1;
        rv_data <= mem[data_addr[9:2]];
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    ex_we = we; ex_size = sz; ex_uns = uns; ex_addr = a; ex_wdata = wd; ex_req = 1'b1;
  endtask

  // Full transaction; returns in the cycle where lsu_done is high.
  task automatic run_txn(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
    int n;
    drive(we, sz, uns, a, wd);
    tick;
    ex_req = 1'b0;
    n = 0;
    while (lsu_done !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    checks++;
    if (lsu_done !== 1'b1) begin
      failures++;
      $display("FAIL txn_done addr=%h got=%b exp=1", a, lsu_done);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    checks++;
    if ({lsu_busy, lsu_done, lsu_err, data_req, data_we} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000", {lsu_busy, lsu_done, lsu_err, data_req, data_we});
    end
    checks++;
    if ({lsu_rdata, data_addr, data_wdata, data_be} !== 100'h0) begin
      failures++;
      $display("FAIL reset_data rdata=%h addr=%h wdata=%h be=%b exp all 0", lsu_rdata, data_addr, data_wdata, data_be);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_load_ext;
    run_txn(1'b1, 2'b10, 1'b0, 32'h100, 32'h80FF_1234);
    tick;
    drive(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
    #1;
    checks++;
    if (lsu_busy !== 1'b1) begin failures++; $display("FAIL lb_busy_accept got=%b exp=1", lsu_busy); end
    tick; // T1
    ex_req = 1'b0;
    checks++;
    if ({data_req, data_we, data_be, data_addr} !== {1'b1, 1'b0, 4'b1000, 32'h100}) begin
      failures++;
      $display("FAIL lb_req got req=%b we=%b be=%b addr=%h exp 1 0 1000 00000100", data_req, data_we, data_be, data_addr);
    end
    tick; // T2
    checks++;
    if ({data_req, lsu_done, lsu_busy} !== 3'b001) begin
      failures++;
      $display("FAIL lb_t2 got req/done/busy=%b exp=001", {data_req, lsu_done, lsu_busy});
    end
    tick; // T3
    checks++;
    if (lsu_done !== 1'b1 || lsu_rdata !== 32'hFFFF_FF80 || lsu_busy !== 1'b0) begin
      failures++;
      $display("FAIL lb_done got done=%b rdata=%h busy=%b exp 1 ffffff80 0", lsu_done, lsu_rdata, lsu_busy);
    end
    tick; // T4
    checks++;
    if (lsu_done !== 1'b0) begin failures++; $display("FAIL lb_done_pulse got=%b exp=0", lsu_done); end
    run_txn(1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
    checks++;
    if (lsu_rdata !== 32'h0000_0080) begin failures++; $display("FAIL lbu got=%h exp=00000080", lsu_rdata); end
    tick;
    run_txn(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
    checks++;
    if (lsu_rdata !== 32'hFFFF_80FF) begin failures++; $display("FAIL lh got=%h exp=ffff80ff", lsu_rdata); end
    tick;
  endtask

  task automatic test_store_half;
    int n;
    run_txn(1'b1, 2'b10, 1'b0, 32'h200, 32'h1122_3344);
    tick;
    drive(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_BEEF);
    tick;
    ex_req = 1'b0;
    checks++;
    if ({data_req, data_we, data_be, data_addr, data_wdata} !== {1'b1, 1'b1, 4'b1100, 32'h200, 32'hBEEF_BEEF}) begin
      failures++;
      $display("FAIL sh_req got req=%b we=%b be=%b addr=%h wdata=%h exp 1 1 1100 00000200 beefbeef",
               data_req, data_we, data_be, data_addr, data_wdata);
    end
    n = 0;
    while (lsu_done !== 1'b1 && n < 40) begin tick; n++; end
    checks++;
    if (lsu_done !== 1'b1) begin failures++; $display("FAIL sh_done got=%b exp=1", lsu_done); end
    checks++;
    if (lsu_rdata !== 32'hFFFF_80FF) begin failures++; $display("FAIL sh_rdata_hold got=%h exp=ffff80ff", lsu_rdata); end
    tick;
    checks++;
    if (mem[8'h80] !== 32'hBEEF_3344) begin failures++; $display("FAIL sh_mem got=%h exp=beef3344", mem[8'h80]); end
  endtask

  task automatic test_store_stall;
    int reqc, donec;
    logic stable, busy_ok, done_seen;
    reqc = 0; donec = 0; stable = 1'b1; busy_ok = 1'b1; done_seen = 1'b0;
    gnt_delay = 5;
    drive(1'b1, 2'b10, 1'b0, 32'h300, 32'hDEAD_BEEF);
    tick;
    ex_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (data_req) begin
        reqc++;
        if (data_addr !== 32'h300 || data_be !== 4'b1111 || data_wdata !== 32'hDEAD_BEEF || data_we !== 1'b1)
          stable = 1'b0;
      end
      if (lsu_done === 1'b1) begin
        donec++;
        done_seen = 1'b1;
      end else if (!done_seen && lsu_busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
      tick;
    end
    gnt_delay = 0;
    checks++;
    if (reqc != 6) begin failures++; $display("FAIL sw_stall_req_cycles got=%0d exp=6", reqc); end
    checks++;
    if (!stable) begin failures++; $display("FAIL sw_stall_stable got=0 exp=1"); end
    checks++;
    if (!busy_ok) begin failures++; $display("FAIL sw_stall_busy got=0 exp=1"); end
    checks++;
    if (donec != 1) begin failures++; $display("FAIL sw_stall_done_count got=%0d exp=1", donec); end
    checks++;
    if (mem[8'hC0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sw_stall_mem got=%h exp=deadbeef", mem[8'hC0]); end
  endtask

  task automatic test_illegal;
    logic [1:0]  szs [3];
    logic [31:0] ads [3];
    szs[0] = 2'b10; ads[0] = 32'h101;
    szs[1] = 2'b01; ads[1] = 32'h103;
    szs[2] = 2'b11; ads[2] = 32'h000;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, szs[k], 1'b0, ads[k], 32'h0);
      #1;
      checks++;
      if (lsu_busy !== 1'b0) begin failures++; $display("FAIL illegal%0d_busy got=%b exp=0", k, lsu_busy); end
      tick;
      ex_req = 1'b0;
      checks++;
      if ({lsu_err, data_req} !== 2'b10) begin
        failures++;
        $display("FAIL illegal%0d_err got err/req=%b exp=10", k, {lsu_err, data_req});
      end
      tick;
      checks++;
      if ({lsu_err, data_req, lsu_done} !== 3'b000) begin
        failures++;
        $display("FAIL illegal%0d_after got err/req/done=%b exp=000", k, {lsu_err, data_req, lsu_done});
      end
    end
  endtask

  task automatic test_back_to_back;
    int n;
    drive(1'b1, 2'b10, 1'b0, 32'h40, 32'h1234_5678);
    tick; tick; tick; // T3: store completes while request is still held
    checks++;
    if (lsu_done !== 1'b1) begin failures++; $display("FAIL b2b_store_done got=%b exp=1", lsu_done); end
    drive(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    #1;
    checks++;
    if (lsu_busy !== 1'b1) begin failures++; $display("FAIL b2b_accept_busy got=%b exp=1", lsu_busy); end
    tick;
    ex_req = 1'b0;
    checks++;
    if ({data_req, data_we, data_addr} !== {1'b1, 1'b0, 32'h40}) begin
      failures++;
      $display("FAIL b2b_load_req got req=%b we=%b addr=%h exp 1 0 00000040", data_req, data_we, data_addr);
    end
    n = 0;
    while (lsu_done !== 1'b1 && n < 40) begin tick; n++; end
    checks++;
    if (lsu_done !== 1'b1 || lsu_rdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL b2b_load got done=%b rdata=%h exp 1 12345678", lsu_done, lsu_rdata);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    rv_delay = 2;
    drive(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    tick; // T1
    ex_req = 1'b0;
    tick; // T2, in WAIT_RV
    rst = 1'b1;
    tick; // T3, late rvalid arrives
    rst = 1'b0;
    checks++;
    if ({data_req, lsu_busy, lsu_done} !== 3'b000 || lsu_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid got req/busy/done=%b rdata=%h exp 000 00000000", {data_req, lsu_busy, lsu_done}, lsu_rdata);
    end
    tick;
    checks++;
    if (lsu_done !== 1'b0 || lsu_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_late_rv got done=%b rdata=%h exp 0 00000000", lsu_done, lsu_rdata);
    end
    rv_delay = 1;
  endtask

  initial begin
    test_reset;
    test_load_ext;
    test_store_half;
    test_store_stall;
    test_illegal;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
